sha_msg_schedule: RTL and testbench

- Upstream feeder for the SHA-256 round/compression stage.
- Accepts one 512-bit padded message block and expands it into the 64-word schedule W[0..63].
- Presents one W[t] together with the matching round constant K[t] per clock, with an enable strobe that drives the compression stage's enable.
- Signals completion so the top-level controller can add the working variables into the hash state.

---
 rtl/sha_msg_schedule_if.sv | 35 +++
 rtl/sha_msg_schedule.sv | 141 ++++++++++++++
 tb/tb_sha_msg_schedule.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha_msg_schedule_if.sv
// sha_msg_schedule_if: bus between the SHA-256 schedule feeder and its controller.
// The stall member and its modport entries exist only when SHA_SCHED_STALL_EN is defined.
interface sha_msg_schedule_if;
  logic         start;
  logic [511:0] block_in;
  logic         ready;
  logic         round_en;
  logic [31:0]  w_i;
  logic [31:0]  k_i;
  logic [5:0]   round_idx;
  logic         done;
`ifdef SHA_SCHED_STALL_EN
  logic         stall;

  modport master (
    output start, block_in, stall,
    input  ready, round_en, w_i, k_i, round_idx, done
  );

  modport slave (
    input  start, block_in, stall,
    output ready, round_en, w_i, k_i, round_idx, done
  );
`else
  modport master (
    output start, block_in,
    input  ready, round_en, w_i, k_i, round_idx, done
  );

  modport slave (
    input  start, block_in,
    output ready, round_en, w_i, k_i, round_idx, done
  );
`endif
endinterface

// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule: expands one 512-bit padded block into the SHA-256 schedule
// W[0..ROUNDS-1] and streams W[t]/K[t] one round per clock.
// Optional macro SHA_SCHED_STALL_EN adds bus.stall, which freezes the current round.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready=1, waiting for start; block loaded on the accepting edge
// RUN   | one round per (non-stalled) cycle, round_en=1
// DONE  | one-cycle done pulse, then back to IDLE
module sha_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sha_msg_schedule_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic        advance;
  logic        in_run;

`ifdef SHA_SCHED_STALL_EN
  assign advance = ~bus.stall;
`else
  assign advance = 1'b1;
`endif

  assign in_run = (state_q == S_RUN);

  // Register state, round counter and the sliding 16-word window.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Next state: load on start, shift/expand each advancing round, leave after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          for (int i = 0; i < 16; i++) begin
            win_d[i] = bus.block_in[511 - 32*i -: 32];
          end
        end
      end

      S_RUN: begin
        if (advance) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          // window[14]=W[t+14], [9]=W[t+9], [1]=W[t+1], [0]=W[t] -> W[t+16]
          win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
          if (cnt_q == LAST_T) begin
            state_d = S_DONE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Outputs are decoded from registers only; W/K are zeroed outside RUN.
  always_comb begin
    bus.ready     = (state_q == S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.round_en  = in_run & advance;
    bus.round_idx = cnt_q;
    bus.w_i       = in_run ? win_q[0] : 32'd0;
    bus.k_i       = in_run ? K_ROM[cnt_q] : 32'd0;
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// tb_sha_msg_schedule: directed bench for sha_msg_schedule using the "abc" block.
// Build with SHA_SCHED_STALL_EN defined to also exercise the stall input.
module tb_sha_msg_schedule;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  sha_msg_schedule_if bus();

  sha_msg_schedule #(.ROUNDS(64)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wexp [64];
  logic [31:0] ha, hb, hc, hd, he, hf, hg, hh;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference schedule in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form.
  task automatic build_model();
    for (int t = 0; t < 16; t++) wexp[t] = ABC_BLK[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      wexp[t] = (rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10))
              + wexp[t-7]
              + (rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3))
              + wexp[t-16];
    end
  endtask

  task automatic compress_step(input logic [31:0] w, input logic [31:0] k);
    logic [31:0] t1, t2;
    t1 = hh + (rotr(he, 6) ^ rotr(he, 11) ^ rotr(he, 25)) + ((he & hf) ^ (~he & hg)) + k + w;
    t2 = (rotr(ha, 2) ^ rotr(ha, 13) ^ rotr(ha, 22)) + ((ha & hb) ^ (ha & hc) ^ (hb & hc));
    hh = hg; hg = hf; hf = he; he = hd + t1;
    hd = hc; hc = hb; hb = ha; ha = t1 + t2;
  endtask

  task automatic count_rounds(output int n);
    n = 0;
    while (bus.round_en === 1'b1 && n < 64) begin
      check_val("seq_idx", 32'(bus.round_idx), 32'(n));
      check_val("seq_w", bus.w_i, wexp[n]);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_gap(output int g);
    g = 0;
    while (bus.round_en !== 1'b1 && g < 50) begin
      g++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, g, dones;
    build_model();
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.block_in = ABC_BLK;
`ifdef SHA_SCHED_STALL_EN
    bus.stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      check_val("idle_ready", 32'(bus.ready), 32'd1);
      check_val("idle_round_en", 32'(bus.round_en), 32'd0);
      check_val("idle_done", 32'(bus.done), 32'd0);
      check_val("idle_w", bus.w_i, 32'd0);
      check_val("idle_k", bus.k_i, 32'd0);
      check_val("idle_idx", 32'(bus.round_idx), 32'd0);
      @(negedge clk);
    end

    // single block, full compression
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ha = 32'h6a09e667; hb = 32'hbb67ae85; hc = 32'h3c6ef372; hd = 32'ha54ff53a;
    he = 32'h510e527f; hf = 32'h9b05688c; hg = 32'h1f83d9ab; hh = 32'h5be0cd19;
    for (int t = 0; t < 64; t++) begin
      check_val("run_round_en", 32'(bus.round_en), 32'd1);
      check_val("run_ready", 32'(bus.ready), 32'd0);
      check_val("run_idx", 32'(bus.round_idx), 32'(t));
      check_val("run_w", bus.w_i, wexp[t]);
      check_val("run_k", bus.k_i, KT[t]);
      if (t == 0)  check_val("w0_abc", bus.w_i, 32'h61626380);
      if (t == 0)  check_val("k0", bus.k_i, 32'h428a2f98);
      if (t == 16) check_val("w16_abc", bus.w_i, 32'h61626380);
      if (t == 17) check_val("w17_abc", bus.w_i, 32'h000f0000);
      if (t == 63) check_val("k63", bus.k_i, 32'hc67178f2);
      compress_step(bus.w_i, bus.k_i);
      @(negedge clk);
    end
    check_val("end_round_en", 32'(bus.round_en), 32'd0);
    check_val("end_done", 32'(bus.done), 32'd1);
    check_val("end_ready", 32'(bus.ready), 32'd0);
    check_val("end_w", bus.w_i, 32'd0);
    @(negedge clk);
    check_val("post_done", 32'(bus.done), 32'd0);
    check_val("post_ready", 32'(bus.ready), 32'd1);
    check_val("digest_a", ha + 32'h6a09e667, 32'hba7816bf);

    // start held high: back-to-back blocks
    bus.start = 1'b1;
    @(negedge clk);
    count_rounds(n);
    check_val("b2b_rounds1", 32'(n), 32'd64);
    count_gap(g);
    check_val("b2b_gap", 32'(g), 32'd2);
    count_rounds(n);
    check_val("b2b_rounds2", 32'(n), 32'd64);
    bus.start = 1'b0;
    check_val("b2b_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check_val("b2b_ready", 32'(bus.ready), 32'd1);
    check_val("b2b_done_off", 32'(bus.done), 32'd0);

    // reset in the middle of a block
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    check_val("rst_pre_idx", 32'(bus.round_idx), 32'd30);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check_val("rst_ready", 32'(bus.ready), 32'd1);
    check_val("rst_round_en", 32'(bus.round_en), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_w", bus.w_i, 32'd0);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    check_val("rst_no_done", 32'(dones), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_val("rerun_w0", bus.w_i, 32'h61626380);
    check_val("rerun_k0", bus.k_i, 32'h428a2f98);
    count_rounds(n);
    check_val("rerun_rounds", 32'(n), 32'd64);
    check_val("rerun_done", 32'(bus.done), 32'd1);
    @(negedge clk);

`ifdef SHA_SCHED_STALL_EN
    begin
      int cyc, rounds;
      bit got_done;
      cyc = 0; rounds = 0; got_done = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < 200 && !got_done) begin
        bus.stall = (cyc >= 20 && cyc < 23);
        #1;
        if (bus.done === 1'b1) begin
          got_done = 1'b1;
        end else begin
          if (bus.round_en === 1'b1) rounds++;
          if (cyc >= 20 && cyc < 23) begin
            check_val("stall_round_en", 32'(bus.round_en), 32'd0);
            check_val("stall_idx", 32'(bus.round_idx), 32'd20);
            check_val("stall_w", bus.w_i, wexp[20]);
            check_val("stall_k", bus.k_i, KT[20]);
          end
          cyc++;
          @(negedge clk);
        end
      end
      bus.stall = 1'b0;
      check_val("stall_rounds", 32'(rounds), 32'd64);
      check_val("stall_done_cycle", 32'(cyc), 32'd67);
      @(negedge clk);
      check_val("stall_ready", 32'(bus.ready), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
